spell_trace_capture: RTL and testbench
======================================

Name: spell_trace_capture

Overview:
- Player-side producer of the 16-bit traced mask `p1_traced` that the tutorial/duel trace checker compares against the displayed pattern.
- Samples the player's cursor cell on a 4x4 grid while the pen is down and builds the mask one cell per move.
- Enforces grid adjacency between moves and closes the stroke on pen-up or inactivity.
- Freezes the result for the checker until it is cleared.

Parameters:
- TIMEOUT_CYCLES, 25_000_000: idle cycles in DRAWING, with no accepted sample, before the stroke auto-closes.
- TMR_W, 25: width of the idle counter. Must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- trace_screen_on  input  1  trace screen active; low forces IDLE and clears the trace
- pen_down  input  1  level, player is drawing
- cell_valid  input  1  one-cycle strobe; cell_x/cell_y hold a new cursor sample
- cell_x  input  2  cursor column 0-3
- cell_y  input  2  cursor row 0-3
- clear_trace  input  1  one-cycle strobe from the checker; discard the trace and restart
- p1_traced  output  16  visited-cell mask; bit index = {cell_y, cell_x}
- trace_ready  output  1  high while state==HOLD (mask frozen)
- trace_done  output  1  one-cycle pulse on DRAWING->HOLD
- bad_move  output  1  one-cycle pulse when a non-adjacent sample is rejected
- step_count  output  5  accepted moves to a new cell, saturating at 31

Behaviour:
- Reset values, async on reset_n low:
  - p1_traced=0, step_count=0, trace_ready=0, trace_done=0, bad_move=0.
  - state=IDLE, last_cell=0, idle counter=0.
- All outputs are registered. p1_traced reflects an accepted sample on the cycle after cell_valid.
- Event priority in every state, highest first: trace_screen_on low, then clear_trace, then sample/pen/timeout events.
- trace_screen_on low (any state):
  - next state IDLE; p1_traced=0, step_count=0.
  - trace_done and bad_move are not asserted.
- clear_trace (any state): next state IDLE; p1_traced=0, step_count=0. A coincident cell_valid is ignored.
- IDLE:
  - Leaves only on trace_screen_on & pen_down & cell_valid: go to DRAWING.
  - On that transition: p1_traced = one-hot at idx, last_cell=idx, step_count=1, idle counter=0.
- DRAWING:
  - pen_down low: go to HOLD, trace_done pulse. A coincident cell_valid is ignored.
  - cell_valid & pen_down, idx==last_cell: no mask change; idle counter cleared.
  - cell_valid & pen_down, idx adjacent to last_cell:
    - p1_traced |= bit idx; last_cell=idx; step_count+1 (saturate at 31); idle counter cleared.
    - Revisiting an already-set cell still counts as a step.
  - cell_valid & pen_down, idx not adjacent:
    - bad_move pulse; mask, last_cell and step_count unchanged.
    - Idle counter not cleared.
  - Otherwise the idle counter increments. When it equals TIMEOUT_CYCLES-1: go to HOLD, trace_done pulse, counter cleared.
- Adjacency: max(|dx|,|dy|)==1 or 4-neighbour only, per DIAGONAL_MOVES_EN. Computed on unsigned 2-bit coordinates with no wrap-around: x=3 to x=0 is not adjacent.
- HOLD:
  - p1_traced and step_count held; trace_ready=1.
  - cell_valid and pen_down are ignored.
  - Exits only via clear_trace or trace_screen_on low.
- trace_done and bad_move are never asserted in the same cycle.

Optional Feature:
- Macro SPELL_TRACE_DIAGONAL_MOVES_EN.
- Defined: diagonal neighbours (|dx|==1 and |dy|==1) are adjacent.
- Undefined: only |dx|+|dy|==1 is adjacent; diagonal samples pulse bad_move.

Decomposition:
- Package spell_trace_pkg holds:
  - state enum {IDLE, DRAWING, HOLD}
  - GRID_DIM=4, MASK_W=16
  - cell-index helper mapping (x,y) to {y,x}
- Sub-module trace_idle_timer: TMR_W counter with clear and enable inputs; `expired` is asserted at TIMEOUT_CYCLES-1.
- Adjacency check stays inline.

Test Plan:
- Reset, then screen on, pen_down, cell_valid at (1,1) -> next cycle p1_traced=16'h0020, step_count=1, state DRAWING.
- Moves (1,1)->(2,1)->(2,2) then pen_down low -> p1_traced=16'h0460, step_count=3, one trace_done pulse, trace_ready=1.
- Move (0,0)->(2,0) -> bad_move pulse, p1_traced stays 16'h0001. Move (0,0)->(1,1): with SPELL_TRACE_DIAGONAL_MOVES_EN p1_traced=16'h0021; without it, bad_move and mask unchanged.
- TIMEOUT_CYCLES=8, one cell, no further samples -> trace_done exactly 8 cycles after the last accepted sample; mask frozen.
- In HOLD, clear_trace together with cell_valid -> IDLE, p1_traced=0, step_count=0, sample not recorded.
- trace_screen_on dropped mid-DRAWING with cell_valid -> IDLE, mask 0, no trace_done. Separately, reset_n pulsed mid-stroke -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spell_trace_pkg.sv
// spell_trace_pkg: shared types, sizes and cell-index helper for the trace capture block
package spell_trace_pkg;
    typedef enum logic [1:0] {IDLE, DRAWING, HOLD} state_t;
    localparam int GRID_DIM = 4;
    localparam int MASK_W   = GRID_DIM * GRID_DIM;
    function automatic logic [3:0] cell_idx(input logic [1:0] x, input logic [1:0] y);
        return {y, x};
    endfunction
endpackage

// File: rtl/trace_idle_timer.sv
// trace_idle_timer: idle-cycle counter, expired when it reaches TIMEOUT_CYCLES-1
//   clk, reset_n : clock, async active-low reset
//   clear        : return count to 0 (wins over enable)
//   enable       : count up one idle cycle
//   expired      : count == TIMEOUT_CYCLES-1
module trace_idle_timer #(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int TMR_W          = 25
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TMR_W-1:0] count;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)    count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    assign expired = (count == TMR_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/spell_trace_capture.sv
// spell_trace_capture: builds the player's 4x4 traced-cell mask from pen/cursor samples
//   clk, reset_n     : clock, async active-low reset
//   trace_screen_on  : low forces IDLE and clears the trace
//   pen_down         : player is drawing (level)
//   cell_valid       : strobe, cell_x/cell_y carry a new cursor sample
//   clear_trace      : strobe from the checker, discard trace and restart
//   p1_traced        : visited-cell mask, bit {cell_y, cell_x}
//   trace_ready      : mask frozen (HOLD)
//   trace_done       : pulse on stroke close
//   bad_move         : pulse on rejected non-adjacent sample
//   step_count       : accepted moves, saturating at 31
// Build option: define SPELL_TRACE_DIAGONAL_MOVES_EN to accept diagonal neighbours.
module spell_trace_capture
    import spell_trace_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int TMR_W          = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trace_screen_on,
    input  logic              pen_down,
    input  logic              cell_valid,
    input  logic [1:0]        cell_x,
    input  logic [1:0]        cell_y,
    input  logic              clear_trace,
    output logic [MASK_W-1:0] p1_traced,
    output logic              trace_ready,
    output logic              trace_done,
    output logic              bad_move,
    output logic [4:0]        step_count
);
    state_t state, state_next;
    logic [3:0] last_cell, idx, last_next;
    logic [1:0] dx, dy;
    logic [2:0] dsum;
    logic kill, draw, start, pen_up, same, adj, step, bad, idle_ev, expired, timeout;
    logic [MASK_W-1:0] onehot, mask_next;
    logic [4:0] steps_next;

    assign idx    = cell_idx(cell_x, cell_y);
    assign onehot = MASK_W'(1) << idx;
    // Distances on unsigned coordinates, so column 3 and column 0 are never neighbours.
    assign dx     = (cell_x >= last_cell[1:0]) ? cell_x - last_cell[1:0] : last_cell[1:0] - cell_x;
    assign dy     = (cell_y >= last_cell[3:2]) ? cell_y - last_cell[3:2] : last_cell[3:2] - cell_y;
    assign dsum   = {1'b0, dx} + {1'b0, dy};
`ifdef SPELL_TRACE_DIAGONAL_MOVES_EN
    assign adj    = (dx <= 2'd1) && (dy <= 2'd1) && (dsum != 3'd0);
`else
    assign adj    = (dsum == 3'd1);
`endif

    assign kill    = !trace_screen_on || clear_trace;
    assign draw    = (state == DRAWING) && !kill;
    assign start   = (state == IDLE) && !kill && pen_down && cell_valid;
    assign pen_up  = draw && !pen_down;
    assign same    = draw && pen_down && cell_valid && (idx == last_cell);
    assign step    = draw && pen_down && cell_valid && adj;
    assign bad     = draw && pen_down && cell_valid && !adj && (idx != last_cell);
    assign idle_ev = draw && pen_down && !cell_valid;
    assign timeout = idle_ev && expired;

    // A rejected sample neither clears nor advances the idle count.
    trace_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMR_W(TMR_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!draw || same || step || pen_up || timeout),
        .enable  (idle_ev),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_next;

    always_comb begin
        state_next = state;
        if (kill)                          state_next = IDLE;
        else if (start)                    state_next = DRAWING;
        else if (pen_up || timeout)        state_next = HOLD;
    end

    always_comb begin
        mask_next  = kill ? '0 : start ? onehot : step ? (p1_traced | onehot) : p1_traced;
        steps_next = kill ? 5'd0 : start ? 5'd1 :
                     step ? ((step_count == 5'd31) ? step_count : step_count + 5'd1) : step_count;
        last_next  = (start || step) ? idx : last_cell;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            p1_traced  <= '0;
            step_count <= '0;
            last_cell  <= '0;
            trace_done <= 1'b0;
            bad_move   <= 1'b0;
        end else begin
            p1_traced  <= mask_next;
            step_count <= steps_next;
            last_cell  <= last_next;
            trace_done <= pen_up || timeout;
            bad_move   <= bad;
        end

    assign trace_ready = (state == HOLD);
endmodule

// File: tb/tb_spell_trace_capture.sv
// tb_spell_trace_capture: table vectors, corner sequences and random stimulus against a reference model
module tb_spell_trace_capture;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_screen_on = 1'b0, pen_down = 1'b0, cell_valid = 1'b0, clear_trace = 1'b0;
    logic [1:0]  cell_x = '0, cell_y = '0;
    logic [15:0] p1_traced;
    logic        trace_ready, trace_done, bad_move;
    logic [4:0]  step_count;

    int n_checks = 0, n_fail = 0;

    spell_trace_capture #(.TIMEOUT_CYCLES(T), .TMR_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .trace_screen_on(trace_screen_on), .pen_down(pen_down),
        .cell_valid(cell_valid), .cell_x(cell_x), .cell_y(cell_y), .clear_trace(clear_trace),
        .p1_traced(p1_traced), .trace_ready(trace_ready), .trace_done(trace_done),
        .bad_move(bad_move), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 drawing, 2 frozen.
    int          m_phase, m_idle, m_lx, m_ly, m_steps;
    logic [15:0] m_mask;
    logic        m_done, m_bad;

    task automatic model_reset();
        m_phase = 0; m_idle = 0; m_lx = 0; m_ly = 0; m_steps = 0;
        m_mask = '0; m_done = 0; m_bad = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic v,
                              input int x, input int y, input logic c);
        int ax, ay;
        bit ok;
        m_done = 0; m_bad = 0;
        ax = (x > m_lx) ? x - m_lx : m_lx - x;
        ay = (y > m_ly) ? y - m_ly : m_ly - y;
`ifdef SPELL_TRACE_DIAGONAL_MOVES_EN
        ok = ((ax > ay) ? ax : ay) == 1;
`else
        ok = (ax + ay) == 1;
`endif
        if (!s || c) begin
            m_phase = 0; m_mask = '0; m_steps = 0; m_idle = 0;
        end else if (m_phase == 0) begin
            if (p && v) begin
                m_phase = 1; m_mask = 16'(1 << (y * 4 + x)); m_lx = x; m_ly = y;
                m_steps = 1; m_idle = 0;
            end
        end else if (m_phase == 1) begin
            if (!p) begin
                m_phase = 2; m_done = 1; m_idle = 0;
            end else if (v) begin
                if (x == m_lx && y == m_ly) m_idle = 0;
                else if (ok) begin
                    m_mask = m_mask | 16'(1 << (y * 4 + x));
                    m_lx = x; m_ly = y; m_idle = 0;
                    m_steps = (m_steps < 31) ? m_steps + 1 : 31;
                end else m_bad = 1;
            end else if (m_idle == T - 1) begin
                m_phase = 2; m_done = 1; m_idle = 0;
            end else m_idle++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".mask"},  int'(p1_traced),   int'(m_mask));
        chk({tag, ".steps"}, int'(step_count),  m_steps);
        chk({tag, ".ready"}, int'(trace_ready), int'(m_phase == 2));
        chk({tag, ".done"},  int'(trace_done),  int'(m_done));
        chk({tag, ".bad"},   int'(bad_move),    int'(m_bad));
    endtask

    // One clock: drive inputs, advance model, compare after the edge.
    task automatic cyc(input logic s, input logic p, input logic v,
                       input int x, input int y, input logic c, input string tag);
        trace_screen_on = s; pen_down = p; cell_valid = v;
        cell_x = 2'(x); cell_y = 2'(y); clear_trace = c;
        @(posedge clk);
        model_step(s, p, v, x, y, c);
        #1;
        chk_model(tag);
    endtask

    task automatic do_reset();
        trace_screen_on = 0; pen_down = 0; cell_valid = 0; clear_trace = 0;
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    typedef struct {
        logic s, p, v, c;
        int x, y;
        logic [15:0] mask;
        int steps;
        logic rdy, done, bad;
    } vec_t;

    vec_t tv[15];

    initial begin
        tv[0]  = '{1,1,1,0, 1,1, 16'h0020, 1, 0,0,0};
        tv[1]  = '{1,1,1,0, 2,1, 16'h0060, 2, 0,0,0};
        tv[2]  = '{1,1,1,0, 2,2, 16'h0460, 3, 0,0,0};
        tv[3]  = '{1,0,0,0, 0,0, 16'h0460, 3, 1,1,0};
        tv[4]  = '{1,0,0,0, 0,0, 16'h0460, 3, 1,0,0};
        tv[5]  = '{1,1,1,0, 3,3, 16'h0460, 3, 1,0,0};
        tv[6]  = '{1,1,1,1, 0,0, 16'h0000, 0, 0,0,0};
        tv[7]  = '{1,1,1,0, 0,0, 16'h0001, 1, 0,0,0};
        tv[8]  = '{1,1,1,0, 2,0, 16'h0001, 1, 0,0,1};
`ifdef SPELL_TRACE_DIAGONAL_MOVES_EN
        tv[9]  = '{1,1,1,0, 1,1, 16'h0021, 2, 0,0,0};
`else
        tv[9]  = '{1,1,1,0, 1,1, 16'h0001, 1, 0,0,1};
`endif
        tv[10] = '{0,1,1,0, 0,1, 16'h0000, 0, 0,0,0};
        tv[11] = '{1,1,1,0, 3,0, 16'h0008, 1, 0,0,0};
        tv[12] = '{1,1,1,0, 0,0, 16'h0008, 1, 0,0,1};
        tv[13] = '{1,1,1,0, 3,0, 16'h0008, 1, 0,0,0};
        tv[14] = '{1,1,0,1, 0,0, 16'h0000, 0, 0,0,0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.mask", int'(p1_traced), 0);
        chk("reset.steps", int'(step_count), 0);
        chk("reset.ready", int'(trace_ready), 0);
        chk("reset.done", int'(trace_done), 0);
        chk("reset.bad", int'(bad_move), 0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            trace_screen_on = tv[i].s; pen_down = tv[i].p; cell_valid = tv[i].v;
            cell_x = 2'(tv[i].x); cell_y = 2'(tv[i].y); clear_trace = tv[i].c;
            @(posedge clk);
            model_step(tv[i].s, tv[i].p, tv[i].v, tv[i].x, tv[i].y, tv[i].c);
            #1;
            chk($sformatf("tv%0d.mask", i),  int'(p1_traced),   int'(tv[i].mask));
            chk($sformatf("tv%0d.steps", i), int'(step_count),  tv[i].steps);
            chk($sformatf("tv%0d.ready", i), int'(trace_ready), int'(tv[i].rdy));
            chk($sformatf("tv%0d.done", i),  int'(trace_done),  int'(tv[i].done));
            chk($sformatf("tv%0d.bad", i),   int'(bad_move),    int'(tv[i].bad));
        end

        // Timeout: trace_done exactly T cycles after the last accepted sample.
        cyc(1, 1, 1, 3, 3, 0, "to.start");
        for (int k = 1; k <= T + 2; k++) begin
            cyc(1, 1, 0, 0, 0, 0, "to.idle");
            chk("to.done_at", int'(trace_done), int'(k == T));
            chk("to.frozen", int'(p1_traced), 16'h8000);
        end
        cyc(1, 1, 0, 0, 0, 1, "to.clear");

        // Step count saturates at 31 while revisiting cells.
        cyc(1, 1, 1, 0, 0, 0, "sat.start");
        for (int k = 0; k < 36; k++) cyc(1, 1, 1, (k % 2 == 0) ? 1 : 0, 0, 0, "sat.move");
        chk("sat.steps", int'(step_count), 31);
        chk("sat.mask", int'(p1_traced), 16'h0003);

        // Screen drop mid-stroke with a sample: no done pulse, mask cleared.
        cyc(1, 1, 1, 1, 0, 0, "drop.move");
        cyc(0, 1, 1, 2, 0, 0, "drop.off");
        chk("drop.done", int'(trace_done), 0);
        chk("drop.mask", int'(p1_traced), 0);

        // Asynchronous reset mid-stroke.
        cyc(1, 1, 1, 2, 2, 0, "ar.start");
        cyc(1, 1, 1, 2, 3, 0, "ar.move");
        #2 reset_n = 0;
        #1;
        chk("ar.mask", int'(p1_traced), 0);
        chk("ar.steps", int'(step_count), 0);
        chk("ar.ready", int'(trace_ready), 0);
        chk("ar.done", int'(trace_done), 0);
        chk("ar.bad", int'(bad_move), 0);
        do_reset();

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            logic s, p, v, c;
            s = ($urandom_range(63) != 0);
            p = ($urandom_range(19) != 0);
            v = ($urandom_range(3) == 0);
            c = ($urandom_range(99) == 0);
            cyc(s, p, v, int'($urandom_range(3)), int'($urandom_range(3)), c, "rnd");
            n_checks++;
            if (trace_done && bad_move) begin
                n_fail++;
                $display("FAIL rnd.exclusive: done=%0b bad=%0b, required not both", trace_done, bad_move);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
